// File: rtl/alu_share_arb_pkg.sv
// Shared constants for the arbitrated ALU front end: datapath widths, requester limit and ALU
// opcodes, plus the round-robin pointer advance helper.
package alu_share_arb_pkg;

  localparam int unsigned ALU_ARB_REQ_NUM_MAX = 4;
  localparam int unsigned DATA_WIDTH_GPR      = 32;
  localparam int unsigned DATA_WIDTH_ALU_OP   = 4;

  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ADD  = 4'h0;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SUB  = 4'h1;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_AND  = 4'h2;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_OR   = 4'h3;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_XOR  = 4'h4;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLL  = 4'h5;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRL  = 4'h6;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRA  = 4'h7;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLT  = 4'h8;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLTU = 4'h9;

  // Wraps explicitly so non-power-of-two requester counts never reach an unused index.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational integer ALU; unknown opcodes return zero.
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [DATA_WIDTH_ALU_OP-1:0] i_op,
  input  logic [DATA_WIDTH_GPR-1:0]    i_in_0,
  input  logic [DATA_WIDTH_GPR-1:0]    i_in_1,
  output logic [DATA_WIDTH_GPR-1:0]    o_out
);

  logic [4:0] w_shamt;
  assign w_shamt = i_in_1[4:0];

  always_comb begin
    o_out = '0;
    case (i_op)
      ALU_OP_ADD:  o_out = i_in_0 + i_in_1;
      ALU_OP_SUB:  o_out = i_in_0 - i_in_1;
      ALU_OP_AND:  o_out = i_in_0 & i_in_1;
      ALU_OP_OR:   o_out = i_in_0 | i_in_1;
      ALU_OP_XOR:  o_out = i_in_0 ^ i_in_1;
      ALU_OP_SLL:  o_out = i_in_0 << w_shamt;
      ALU_OP_SRL:  o_out = i_in_0 >> w_shamt;
      ALU_OP_SRA:  o_out = $unsigned($signed(i_in_0) >>> w_shamt);
      ALU_OP_SLT:  o_out = {{(DATA_WIDTH_GPR-1){1'b0}}, $signed(i_in_0) < $signed(i_in_1)};
      ALU_OP_SLTU: o_out = {{(DATA_WIDTH_GPR-1){1'b0}}, i_in_0 < i_in_1};
      default:     o_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_sel.sv
// Combinational grant picker: round-robin from i_ptr when i_rr_en is set, else index 0 first.
module alu_share_sel #(
  parameter int unsigned REQ_NUM = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic [REQ_NUM-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_rr_en,
  output logic [REQ_NUM-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      int unsigned j;
      j = i_rr_en ? ((32'(i_ptr) + k) % REQ_NUM) : k;
      if (!w_found && i_req_valid[j]) begin
        w_found = 1'b1;
        w_idx   = j[ID_W-1:0];
      end
    end
  end

  assign o_idx   = w_idx;
  assign o_grant = w_found ? (REQ_NUM'(1) << w_idx) : '0;

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrated front end for the shared ALU with a one-entry tagged response slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (index 0 first) otherwise.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [REQ_NUM-1:0]                   req_valid,
  input  logic [REQ_NUM*DATA_WIDTH_ALU_OP-1:0] req_op,
  input  logic [REQ_NUM*DATA_WIDTH_GPR-1:0]    req_in_0,
  input  logic [REQ_NUM*DATA_WIDTH_GPR-1:0]    req_in_1,
  output logic [REQ_NUM-1:0]                   req_ready,
  output logic                                 rsp_valid,
  output logic [ID_W-1:0]                      rsp_id,
  output logic [DATA_WIDTH_GPR-1:0]            rsp_data,
  input  logic                                 rsp_ready
);

  logic                         r_rsp_valid;
  logic [ID_W-1:0]              r_rsp_id;
  logic [DATA_WIDTH_GPR-1:0]    r_rsp_data;

  logic                         w_slot_free;
  logic                         w_accept;
  logic                         w_rr_en;
  logic [ID_W-1:0]              w_ptr;
  logic [REQ_NUM-1:0]           w_grant;
  logic [ID_W-1:0]              w_idx;
  logic [DATA_WIDTH_ALU_OP-1:0] w_op;
  logic [DATA_WIDTH_GPR-1:0]    w_in_0;
  logic [DATA_WIDTH_GPR-1:0]    w_in_1;
  logic [DATA_WIDTH_GPR-1:0]    w_alu_out;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= ID_W'(rr_next(32'(w_idx), REQ_NUM));
    end
  end

  assign w_rr_en = 1'b1;
  assign w_ptr   = r_rr_ptr;
`else
  assign w_rr_en = 1'b0;
  assign w_ptr   = '0;
`endif

  assign w_slot_free = ~r_rsp_valid | rsp_ready;

  alu_share_sel #(
    .REQ_NUM (REQ_NUM),
    .ID_W    (ID_W)
  ) u_sel (
    .i_req_valid (req_valid),
    .i_ptr       (w_ptr),
    .i_rr_en     (w_rr_en),
    .o_grant     (w_grant),
    .o_idx       (w_idx)
  );

  // The grant vector only has a bit set for a valid requester.
  assign req_ready = w_grant & {REQ_NUM{w_slot_free}};
  assign w_accept  = |(req_valid & req_ready);

  assign w_op   = req_op[32'(w_idx)*DATA_WIDTH_ALU_OP +: DATA_WIDTH_ALU_OP];
  assign w_in_0 = req_in_0[32'(w_idx)*DATA_WIDTH_GPR +: DATA_WIDTH_GPR];
  assign w_in_1 = req_in_1[32'(w_idx)*DATA_WIDTH_GPR +: DATA_WIDTH_GPR];

  alu u_alu (
    .i_op   (w_op),
    .i_in_0 (w_in_0),
    .i_in_1 (w_in_1),
    .o_out  (w_alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_rsp_data  <= w_alu_out;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with three requesters; expectations follow ALU_ARB_RR_EN.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*4-1:0]  req_op;
  logic [N*32-1:0] req_in_0;
  logic [N*32-1:0] req_in_1;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_share_arb #(
    .REQ_NUM (N),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_in_0  (req_in_0),
    .req_in_1  (req_in_1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = v;
    req_op[i*4 +: 4]    = op;
    req_in_0[i*32 +: 32] = a;
    req_in_1[i*32 +: 32] = b;
  endtask

  // One cycle: check req_ready mid-cycle, record the expected response, then pass the edge.
  task automatic step(input logic [N-1:0] exp_rdy, input logic [1:0] id,
                      input logic [31:0] d, input bit push);
    @(negedge clk);
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != '0 && push) q.push_back('{id: id, data: d});
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got id=%0d data=%h expected none", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
        check_eq("rsp_data", rsp_data, e.data);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_in_0  = '0;
    req_in_1  = '0;
    #3;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("reset_rsp_data", rsp_data, 32'd0);
    check_eq("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request: 5 + 7.
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd5, 32'd7);
    step(3'b001, 2'd0, 32'd12, 1'b1);
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0);

    // Back-pressure: req1 waits while the slot is stalled.
    set_req(1, 1'b1, ALU_OP_AND, 32'h0000_FF00, 32'h0000_0FF0);
    step(3'b010, 2'd1, 32'h0000_0F00, 1'b1);
    rsp_ready = 1'b0;
    set_req(1, 1'b1, ALU_OP_OR, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 2'd0, 32'd0, 1'b0);
      check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rsp_data", rsp_data, 32'h0000_0F00);
    end
    rsp_ready = 1'b1;
    step(3'b010, 2'd1, 32'd3, 1'b1);
    set_req(1, 1'b0, ALU_OP_OR, 32'd0, 32'd0);
    step(3'b000, 2'd0, 32'd0, 1'b0);

    // Reset while a result sits in the slot.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd1, 32'd1);
    step(3'b001, 2'd0, 32'd2, 1'b0);
    check_eq("inflight_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("inflight_rsp_data", rsp_data, 32'd2);
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("async_rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("async_rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two contending requesters, consumer always ready.
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, ALU_OP_XOR, 32'h0000_00F0, 32'h0000_000F);
`ifdef ALU_ARB_RR_EN
    step(3'b001, 2'd0, 32'd7, 1'b1);
    step(3'b010, 2'd1, 32'h0000_00FF, 1'b1);
    step(3'b001, 2'd0, 32'd7, 1'b1);
    step(3'b010, 2'd1, 32'h0000_00FF, 1'b1);
`else
    for (int i = 0; i < 4; i++) step(3'b001, 2'd0, 32'd7, 1'b1);
`endif
    set_req(0, 1'b0, ALU_OP_SUB, 32'd0, 32'd0);
    step(3'b010, 2'd1, 32'h0000_00FF, 1'b1);
    set_req(1, 1'b0, ALU_OP_XOR, 32'd0, 32'd0);
    step(3'b000, 2'd0, 32'd0, 1'b0);
    pulse_reset();

    // Three requesters: pointer wraps from index 2 back to 0.
    set_req(0, 1'b1, ALU_OP_SLL, 32'd1, 32'd4);
    set_req(1, 1'b1, ALU_OP_SRA, 32'h8000_0000, 32'd4);
    set_req(2, 1'b1, ALU_OP_ADD, 32'd3, 32'd4);
`ifdef ALU_ARB_RR_EN
    step(3'b001, 2'd0, 32'd16, 1'b1);
    step(3'b010, 2'd1, 32'hF800_0000, 1'b1);
    step(3'b100, 2'd2, 32'd7, 1'b1);
    step(3'b001, 2'd0, 32'd16, 1'b1);
    set_req(0, 1'b0, ALU_OP_SLL, 32'd0, 32'd0);
    step(3'b010, 2'd1, 32'hF800_0000, 1'b1);
    step(3'b100, 2'd2, 32'd7, 1'b1);
`else
    for (int i = 0; i < 4; i++) step(3'b001, 2'd0, 32'd16, 1'b1);
    set_req(0, 1'b0, ALU_OP_SLL, 32'd0, 32'd0);
    step(3'b010, 2'd1, 32'hF800_0000, 1'b1);
    step(3'b010, 2'd1, 32'hF800_0000, 1'b1);
`endif
    set_req(1, 1'b0, ALU_OP_SRA, 32'd0, 32'd0);
    step(3'b100, 2'd2, 32'd7, 1'b1);

    // Undefined opcode yields zero.
    set_req(2, 1'b1, 4'hF, 32'd5, 32'd5);
    step(3'b100, 2'd2, 32'd0, 1'b1);
    set_req(2, 1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    step(3'b000, 2'd0, 32'd0, 1'b0);
    step(3'b000, 2'd0, 32'd0, 1'b0);

    check_eq("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
